// File: rtl/mips_wb_checker_if.sv
// ----------------------------------------------------------------------------
// mips_wb_checker_if
// Bundles the programming, store-bus and status signals of mips_wb_checker.
//   master : bench / controller side. Drives start, exp_* and the dmem_* store
//            bus. Reads the status outputs.
//   slave  : checker side. The mirror image of master.
// Signals:
//   start, exp_count      begin a check with exp_count table entries
//   exp_we/idx/addr/data  expected-table write port
//   dmem_write/addr/      store bus being monitored
//     dmem_write_data
//   busy, done, pass,     registered status
//     fail, timeout
//   match_count           entries matched so far
//   fail_addr, fail_data  offending store (0 on timeout)
// ----------------------------------------------------------------------------
interface mips_wb_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             start;
  logic [CW-1:0]    exp_count;
  logic             exp_we;
  logic [IW-1:0]    exp_idx;
  logic [WIDTH-1:0] exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic             dmem_write;
  logic [WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_write_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [CW-1:0]    match_count;
  logic [WIDTH-1:0] fail_addr;
  logic [WIDTH-1:0] fail_data;

  modport master (
    output start, exp_count, exp_we, exp_idx, exp_addr, exp_data,
           dmem_write, dmem_addr, dmem_write_data,
    input  busy, done, pass, fail, timeout, match_count, fail_addr, fail_data
  );

  modport slave (
    input  start, exp_count, exp_we, exp_idx, exp_addr, exp_data,
           dmem_write, dmem_addr, dmem_write_data,
    output busy, done, pass, fail, timeout, match_count, fail_addr, fail_data
  );
endinterface

// File: rtl/mips_wb_checker.sv
// ----------------------------------------------------------------------------
// mips_wb_checker
// Self-check monitor for the MIPS data-memory write bus. It compares committed
// stores against a programmable table of expected (address, data) pairs.
// Checking is either strict index order (IN_ORDER=1) or any order. Stores that
// fall in a masked ignore window are skipped unless they hit a table entry.
// The check ends in PASS, or in FAIL on a mismatch or a cycle-budget timeout.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high. Aborts any check and clears the table.
//   bus    mips_wb_checker_if.slave. Holds the table write port, start and
//          exp_count, the dmem store bus, and the registered status outputs.
// ----------------------------------------------------------------------------
module mips_wb_checker #(
  parameter int               WIDTH          = 32,
  parameter int               DEPTH          = 8,
  parameter int               IN_ORDER       = 1,
  parameter int               IGN_EN         = 1,
  parameter logic [WIDTH-1:0] IGN_BASE       = WIDTH'(32510),
  parameter logic [WIDTH-1:0] IGN_MASK       = {WIDTH{1'b1}},
  parameter int               TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  mips_wb_checker_if.slave bus
);
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam int            TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TLIM_C  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_tab_addr [DEPTH];
  logic [WIDTH-1:0] r_tab_data [DEPTH];
  logic [DEPTH-1:0] r_hit, w_hit_next;
  logic [CW-1:0]    r_count, w_count_next;
  logic [CW-1:0]    r_match_cnt, w_match_next, w_match_inc;
  logic [TW-1:0]    r_cyc, w_cyc_next, w_cyc_inc;
  logic             r_timeout, w_timeout_next;
  logic [WIDTH-1:0] r_fail_addr, w_fail_addr_next;
  logic [WIDTH-1:0] r_fail_data, w_fail_data_next;

  logic [DEPTH-1:0] w_eq;       // current store equals entry gi
  logic [DEPTH-1:0] w_valid;    // entry gi lies inside the latched count
  logic [DEPTH-1:0] w_cand;     // valid, equal and not yet hit
  logic [DEPTH-1:0] w_any_sel;  // lowest-index candidate, one-hot
  logic             w_any_found;
  logic             w_cur_eq;   // store equals entry[match_count]
  logic             w_tab_hit;
  logic             w_ignored;
  logic             w_qual;
  logic             w_hit_ok;
  logic             w_expire;
  logic [CW-1:0]    w_count_clamp;

  // Per-entry comparators, evaluated in parallel every cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign w_eq[gi]    = (r_tab_addr[gi] == bus.dmem_addr) &&
                           (r_tab_data[gi] == bus.dmem_write_data);
      assign w_valid[gi] = (CW'(gi) < r_count);
    end
  endgenerate

  assign w_cand    = w_eq & w_valid & ~r_hit;
  assign w_tab_hit = |(w_eq & w_valid);

  // A table match overrides the ignore window, so a scratch-range address can
  // still be checked when the table explicitly expects it.
  assign w_ignored = (IGN_EN != 0) &&
                     ((bus.dmem_addr & IGN_MASK) == IGN_BASE) && !w_tab_hit;
  assign w_qual    = bus.dmem_write && !w_ignored;

  assign w_cyc_inc = r_cyc + 1'b1;
  assign w_expire  = (TIMEOUT_CYCLES != 0) && (w_cyc_inc == TLIM_C);

  assign w_count_clamp = (bus.exp_count > DEPTH_C) ? DEPTH_C : bus.exp_count;

  always_comb begin
    w_any_sel   = '0;
    w_any_found = 1'b0;
    w_cur_eq    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_any_found && w_cand[i]) begin
        w_any_sel[i] = 1'b1;
        w_any_found  = 1'b1;
      end
      if (CW'(i) == r_match_cnt) begin
        w_cur_eq = w_eq[i];
      end
    end
  end

  assign w_hit_ok = (IN_ORDER != 0) ? w_cur_eq : w_any_found;

  // Next-state and datapath update.
  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_match_next     = r_match_cnt;
    w_hit_next       = r_hit;
    w_cyc_next       = r_cyc;
    w_timeout_next   = r_timeout;
    w_fail_addr_next = r_fail_addr;
    w_fail_data_next = r_fail_data;
    w_match_inc      = r_match_cnt + 1'b1;

    unique case (r_state)
      S_RUN: begin
        if (r_cyc != TLIM_C) begin
          w_cyc_next = w_cyc_inc;
        end
        if (r_match_cnt == r_count) begin
          // Only reachable with an empty table: done on the first RUN edge.
          w_state_next = S_PASS;
        end else if (w_qual && !w_hit_ok) begin
          w_state_next     = S_FAIL;
          w_fail_addr_next = bus.dmem_addr;
          w_fail_data_next = bus.dmem_write_data;
        end else begin
          if (w_qual) begin
            w_match_next = w_match_inc;
            if (IN_ORDER == 0) begin
              w_hit_next = r_hit | w_any_sel;
            end
            if (w_match_inc == r_count) begin
              w_state_next = S_PASS;
            end
          end
          // The final match wins over a budget expiring on the same edge.
          if (w_state_next == S_RUN && w_expire) begin
            w_state_next     = S_FAIL;
            w_timeout_next   = 1'b1;
            w_fail_addr_next = '0;
            w_fail_data_next = '0;
          end
        end
      end
      default: begin
        if (bus.start) begin
          w_state_next     = S_RUN;
          w_count_next     = w_count_clamp;
          w_match_next     = '0;
          w_hit_next       = '0;
          w_cyc_next       = '0;
          w_timeout_next   = 1'b0;
          w_fail_addr_next = '0;
          w_fail_data_next = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_match_cnt <= '0;
      r_hit       <= '0;
      r_cyc       <= '0;
      r_timeout   <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_match_cnt <= w_match_next;
      r_hit       <= w_hit_next;
      r_cyc       <= w_cyc_next;
      r_timeout   <= w_timeout_next;
      r_fail_addr <= w_fail_addr_next;
      r_fail_data <= w_fail_data_next;
    end
  end

  // Expected table. It is frozen while a check runs so the reference cannot
  // shift under an active comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tab_addr[i] <= '0;
        r_tab_data[i] <= '0;
      end
    end else if (bus.exp_we && (r_state != S_RUN) && (int'(bus.exp_idx) < DEPTH)) begin
      r_tab_addr[bus.exp_idx] <= bus.exp_addr;
      r_tab_data[bus.exp_idx] <= bus.exp_data;
    end
  end

  assign bus.busy        = (r_state == S_RUN);
  assign bus.pass        = (r_state == S_PASS);
  assign bus.fail        = (r_state == S_FAIL);
  assign bus.done        = (r_state == S_PASS) || (r_state == S_FAIL);
  assign bus.timeout     = r_timeout;
  assign bus.match_count = r_match_cnt;
  assign bus.fail_addr   = r_fail_addr;
  assign bus.fail_data   = r_fail_data;

endmodule
